// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and widths for the alarm sequencer.
//   alarm_state_t : FSM state codes (DISABLED=0, ARMED=1, RINGING=2, SNOOZE=3)
//   HOUR_W/MIN_W/SEC_W : time field widths, TMR_W : seconds timer width
package alarm_pkg;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned TMR_W  = 12;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZE   = 2'd3
    } alarm_state_t;

endpackage

// File: rtl/alarm_sec_timer.sv
// alarm_sec_timer: loadable seconds down-counter.
//   clk, reset   : clock, synchronous active-high reset
//   load_i       : load load_val_i (wins over tick_i)
//   load_val_i   : reload value
//   tick_i       : decrement enable (one per second, gated by the owner FSM)
//   zero_next_o  : count == 1, i.e. the next tick expires the timer (combinational)
module alarm_sec_timer
    import alarm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             tick_i,
    output logic             zero_next_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Never count below 1: the expiring tick is consumed by the FSM instead.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && (cnt_q > TMR_W'(1))) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_next_o = (cnt_q == TMR_W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm sequencer. Arms on alarm_en, rings on a time match,
// handles snooze/stop buttons and ring auto-timeout.
//   clk, reset           : clock, synchronous active-high reset
//   sec_tick             : 1 Hz single-cycle pulse
//   cur_hour/min/sec     : running time (binary)
//   alm_hour/alm_min     : programmed alarm time
//   alarm_en             : arm switch (low forces DISABLED)
//   snooze_btn, stop_btn : single-cycle debounced pulses
//   alarm                : high while RINGING (registered)
//   snoozing             : high while SNOOZE (registered)
//   state                : current state code (registered)
// Optional build macro ALARM_SNOOZE_LIMIT_EN: caps honoured snoozes per
// alarm event at MAX_SNOOZE; without it snoozes are unlimited.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_SEC       = 300,
`ifdef ALARM_SNOOZE_LIMIT_EN
    parameter int unsigned MAX_SNOOZE       = 3,
`endif
    parameter int unsigned RING_TIMEOUT_SEC = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sec_tick,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic [HOUR_W-1:0] alm_hour,
    input  logic [MIN_W-1:0]  alm_min,
    input  logic              alarm_en,
    input  logic              snooze_btn,
    input  logic              stop_btn,
    output logic              alarm,
    output logic              snoozing,
    output logic [1:0]        state
);

    alarm_state_t state_q, state_d;
    logic         alarm_q, alarm_d;
    logic         snoozing_q, snoozing_d;

    logic match_c;
    logic snz_ok_c;
    logic ring_load_c, ring_tick_c, ring_zero_c;
    logic snz_load_c, snz_tick_c, snz_zero_c;

    assign match_c = sec_tick && (cur_hour == alm_hour) && (cur_min == alm_min)
                     && (cur_sec == SEC_W'(0));

    alarm_sec_timer u_ring_tmr (
        .clk         (clk),
        .reset       (reset),
        .load_i      (ring_load_c),
        .load_val_i  (TMR_W'(RING_TIMEOUT_SEC)),
        .tick_i      (ring_tick_c),
        .zero_next_o (ring_zero_c)
    );

    alarm_sec_timer u_snz_tmr (
        .clk         (clk),
        .reset       (reset),
        .load_i      (snz_load_c),
        .load_val_i  (TMR_W'(SNOOZE_SEC)),
        .tick_i      (snz_tick_c),
        .zero_next_o (snz_zero_c)
    );

`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam int unsigned SNZ_CNT_W = 3;
    logic [SNZ_CNT_W-1:0] snz_cnt_q, snz_cnt_d;

    // Cleared when a fresh alarm event starts, bumped on each honoured snooze.
    always_comb begin
        snz_cnt_d = snz_cnt_q;
        if (ring_load_c && (state_q == ST_ARMED)) begin
            snz_cnt_d = '0;
        end else if (snz_load_c) begin
            snz_cnt_d = snz_cnt_q + SNZ_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snz_cnt_q <= '0;
        end else begin
            snz_cnt_q <= snz_cnt_d;
        end
    end

    assign snz_ok_c = (snz_cnt_q != SNZ_CNT_W'(MAX_SNOOZE));
`else
    assign snz_ok_c = 1'b1;
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_DISABLED;
            alarm_q    <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            alarm_q    <= alarm_d;
            snoozing_q <= snoozing_d;
        end
    end

    // Next state and timer controls; a button in a tick cycle suppresses the decrement.
    always_comb begin
        state_d     = state_q;
        ring_load_c = 1'b0;
        ring_tick_c = 1'b0;
        snz_load_c  = 1'b0;
        snz_tick_c  = 1'b0;
        if (!alarm_en) begin
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (match_c) begin
                        state_d     = ST_RINGING;
                        ring_load_c = 1'b1;
                    end
                end
                ST_RINGING: begin
                    if (stop_btn) begin
                        state_d = ST_ARMED;
                    end else if (snooze_btn && snz_ok_c) begin
                        state_d    = ST_SNOOZE;
                        snz_load_c = 1'b1;
                    end else if (sec_tick) begin
                        if (ring_zero_c) begin
                            state_d = ST_ARMED;
                        end else begin
                            ring_tick_c = 1'b1;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (stop_btn) begin
                        state_d = ST_ARMED;
                    end else if (sec_tick) begin
                        if (snz_zero_c) begin
                            state_d     = ST_RINGING;
                            ring_load_c = 1'b1;
                        end else begin
                            snz_tick_c = 1'b1;
                        end
                    end
                end
                default: state_d = ST_DISABLED;
            endcase
        end
    end

    // Outputs decoded from the next state so they register alongside it.
    always_comb begin
        alarm_d    = (state_d == ST_RINGING);
        snoozing_d = (state_d == ST_SNOOZE);
    end

    assign alarm    = alarm_q;
    assign snoozing = snoozing_q;
    assign state    = 2'(state_q);

endmodule

// File: tb/tb_alarm_ctrl.sv
module tb_alarm_ctrl;

    localparam int RT = 60;
    localparam int SS = 300;
`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam int MAXS = 3;
`endif

    logic       clk = 1'b0;
    logic       reset, sec_tick, alarm_en, snooze_btn, stop_btn;
    logic [4:0] cur_hour, alm_hour;
    logic [5:0] cur_min, cur_sec, alm_min;
    logic       alarm, snoozing;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    // Reference model: absolute tick deadlines rather than down-counters.
    int tod;        // time of day in seconds
    int ah, am;     // programmed alarm
    int tick_no;    // ticks seen so far
    int m_state;    // 0 off, 1 armed, 2 ringing, 3 snoozing
    int ring_end, wake_at, snz_used;

    always #5 clk = ~clk;

    alarm_ctrl #(.SNOOZE_SEC(SS), .RING_TIMEOUT_SEC(RT)) dut (
        .clk(clk), .reset(reset), .sec_tick(sec_tick),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .alm_hour(alm_hour), .alm_min(alm_min), .alarm_en(alarm_en),
        .snooze_btn(snooze_btn), .stop_btn(stop_btn),
        .alarm(alarm), .snoozing(snoozing), .state(state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_state"}, 32'(state), 32'(m_state));
        check({tag, "_alarm"}, 32'(alarm), 32'(m_state == 2));
        check({tag, "_snoozing"}, 32'(snoozing), 32'(m_state == 3));
    endtask

    function automatic bit snooze_allowed();
`ifdef ALARM_SNOOZE_LIMIT_EN
        return snz_used < MAXS;
`else
        return 1'b1;
`endif
    endfunction

    task automatic cycle(input bit tk, input bit sb, input bit sp);
        bit match;
        if (tk) begin
            tod = (tod + 1) % 86400;
            tick_no++;
        end
        sec_tick   = tk;
        snooze_btn = sb;
        stop_btn   = sp;
        cur_hour   = 5'(tod / 3600);
        cur_min    = 6'((tod / 60) % 60);
        cur_sec    = 6'(tod % 60);
        alm_hour   = 5'(ah);
        alm_min    = 6'(am);
        match = tk && (tod == ah * 3600 + am * 60);
        if (!alarm_en) m_state = 0;
        else begin
            case (m_state)
                0: m_state = 1;
                1: if (match) begin
                       m_state = 2; ring_end = tick_no + RT; snz_used = 0;
                   end
                2: if (sp) m_state = 1;
                   else if (sb && snooze_allowed()) begin
                       m_state = 3; wake_at = tick_no + SS; snz_used++;
                   end else if (tk && tick_no == ring_end) m_state = 1;
                default: if (sp) m_state = 1;
                   else if (tk && tick_no == wake_at) begin
                       m_state = 2; ring_end = tick_no + RT;
                   end
            endcase
        end
        @(posedge clk);
        #1;
        sec_tick = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
        check_model("cyc");
    endtask

    task automatic sec();
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_state = 0; snz_used = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_model("reset");
    endtask

    // Put the clock one second before the programmed alarm time.
    task automatic jump_to_alarm();
        tod = (ah * 3600 + am * 60 - 1 + 86400) % 86400;
    endtask

    initial begin
        int r;
        reset = 1'b1; sec_tick = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
        alarm_en = 1'b0;
        ah = 7; am = 30; tod = 7 * 3600 + 29 * 60 + 50;
        tick_no = 0; m_state = 0; ring_end = 0; wake_at = 0; snz_used = 0;
        cur_hour = '0; cur_min = '0; cur_sec = '0; alm_hour = 5'(ah); alm_min = 6'(am);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(state), 0);
        check("reset_alarm", 32'(alarm), 0);
        check("reset_snoozing", 32'(snoozing), 0);
        reset = 1'b0;

        // Arm, then run 07:29:51 .. 07:30:00.
        alarm_en = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        check("armed", 32'(state), 1);
        repeat (9) sec();
        check("pre_match_alarm", 32'(alarm), 0);
        sec();
        check("ring_rise_alarm", 32'(alarm), 1);
        check("ring_rise_state", 32'(state), 2);

        // Timeout after 60 ticks.
        repeat (RT - 1) sec();
        check("ring_59_alarm", 32'(alarm), 1);
        sec();
        check("timeout_alarm", 32'(alarm), 0);
        check("timeout_state", 32'(state), 1);

        // Snooze on tick 10, wake after 300 ticks, ring timer reloaded.
        jump_to_alarm();
        sec();
        repeat (9) sec();
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check("snooze_enter", 32'(snoozing), 1);
        check("snooze_alarm", 32'(alarm), 0);
        repeat (SS - 1) sec();
        check("snooze_299", 32'(snoozing), 1);
        sec();
        check("wake_alarm", 32'(alarm), 1);
        check("wake_state", 32'(state), 2);
        repeat (RT - 1) sec();
        check("reload_59", 32'(alarm), 1);
        sec();
        check("reload_timeout", 32'(state), 1);

        // Stop and snooze together: stop wins.
        jump_to_alarm();
        sec();
        cycle(1'b0, 1'b1, 1'b1);
        check("stop_wins_state", 32'(state), 1);
        check("stop_wins_snoozing", 32'(snoozing), 0);

        // Disable from SNOOZE, re-arm, repeat match re-rings.
        jump_to_alarm();
        sec();
        cycle(1'b0, 1'b1, 1'b0);
        check("snooze_again", 32'(state), 3);
        alarm_en = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        check("disable_state", 32'(state), 0);
        alarm_en = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        check("rearm_state", 32'(state), 1);
        jump_to_alarm();
        sec();
        check("rering_alarm", 32'(alarm), 1);
        cycle(1'b0, 1'b0, 1'b1);

`ifdef ALARM_SNOOZE_LIMIT_EN
        // Fourth snooze press is ignored.
        jump_to_alarm();
        sec();
        for (int s = 0; s < MAXS; s++) begin
            cycle(1'b0, 1'b1, 1'b0);
            repeat (SS) sec();
        end
        cycle(1'b0, 1'b1, 1'b0);
        check("limit_ignored_alarm", 32'(alarm), 1);
        cycle(1'b0, 1'b0, 1'b1);
        check("limit_stop_state", 32'(state), 1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                do_reset();
            end else begin
                if (r < 8) alarm_en = ~alarm_en;
                else if (r < 40 && !alarm_en) alarm_en = 1'b1;
                else if (r < 55) jump_to_alarm();
                else if (r < 58) begin
                    ah = int'($urandom_range(0, 23));
                    am = int'($urandom_range(0, 59));
                end
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                      $urandom_range(0, 59) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
